// File: rtl/multi_breathing_light.sv
// multi_breathing_light
//
// Drives CH LED channels, each with its own mode: off, on, breathe (a
// triangle-wave PWM ramp) or blink. All channels share one breathing phase
// counter. Each channel reads that counter with an offset of
// n * (2^(PWM_W+1) / CH), so the channels ramp evenly staggered.
//
// Optional build macro:
//   BREATH_GAMMA_EN  When defined, the breathe duty is (level*level) >> PWM_W.
//                    This gives a perceptual gamma curve. When undefined, the
//                    duty is the linear level and no multiplier is built.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   hold        freezes the prescaler and the phase counter; PWM keeps running
//   mode        2 bits per channel; channel n uses [2n+1:2n]
//               00 off, 01 on, 10 breathe, 11 blink
//   light       registered per-channel LED drive
//   cycle_done  one-cycle pulse when the phase counter wraps to 0
module multi_breathing_light #(
  parameter int CH       = 4,
  parameter int PWM_W    = 8,
  parameter int STEP_DIV = 78125
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic [2*CH-1:0] mode,
  output logic [CH-1:0]   light,
  output logic            cycle_done
);

  localparam int PH_W   = PWM_W + 1;
  localparam int PSC_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int PH_OFF = (2 ** PH_W) / CH;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(STEP_DIV - 1);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_BLINK   = 2'b11;

  logic [PSC_W-1:0] presc;
  logic [PH_W-1:0]  phase;
  logic [PWM_W-1:0] pwm_cnt;
  logic             step;
  logic             pwm_last;

  logic [PH_W-1:0]  ch_phase [CH];
  logic [PWM_W-1:0] ch_level [CH];
  logic [PWM_W-1:0] ch_duty  [CH];
`ifdef BREATH_GAMMA_EN
  logic [2*PWM_W-1:0] ch_sq [CH];
`endif

  // Duty and mode as latched at the last PWM period boundary.
  logic [PWM_W-1:0] act_duty [CH];
  logic [1:0]       act_mode [CH];

  assign step     = (presc == PSC_MAX) && !hold;
  assign pwm_last = (pwm_cnt == '1);

  // Per-channel phase, triangle level and breathe duty.
  always_comb begin
    for (int n = 0; n < CH; n++) begin
      ch_phase[n] = phase + PH_W'(n * PH_OFF);
      // The top phase bit selects the falling half of the triangle.
      ch_level[n] = ch_phase[n][PWM_W] ? ~ch_phase[n][PWM_W-1:0]
                                       :  ch_phase[n][PWM_W-1:0];
`ifdef BREATH_GAMMA_EN
      // Square the level at full width, then keep the upper PWM_W bits.
      ch_sq[n]   = (2*PWM_W)'(ch_level[n]) * (2*PWM_W)'(ch_level[n]);
      ch_duty[n] = ch_sq[n][2*PWM_W-1:PWM_W];
`else
      ch_duty[n] = ch_level[n];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      phase      <= '0;
      pwm_cnt    <= '0;
      cycle_done <= 1'b0;
      light      <= '0;
      for (int n = 0; n < CH; n++) begin
        act_duty[n] <= '0;
        act_mode[n] <= MODE_OFF;
      end
    end else begin
      // The PWM counter keeps running during hold, so the LEDs keep
      // showing the frozen duty.
      pwm_cnt <= pwm_cnt + 1'b1;

      if (!hold) begin
        presc <= (presc == PSC_MAX) ? '0 : presc + 1'b1;
      end

      if (step) begin
        phase <= phase + 1'b1;
      end

      // The pulse appears in the cycle after phase has wrapped to 0.
      cycle_done <= step && (phase == '1);

      for (int n = 0; n < CH; n++) begin
        // Duty and mode are latched only on the last PWM count. This keeps
        // each PWM period clean and delays mode changes to the next period.
        if (pwm_last) begin
          act_duty[n] <= ch_duty[n];
          act_mode[n] <= mode[2*n +: 2];
        end

        case (act_mode[n])
          MODE_OFF:     light[n] <= 1'b0;
          MODE_ON:      light[n] <= 1'b1;
          MODE_BREATHE: light[n] <= (pwm_cnt < act_duty[n]);
          MODE_BLINK:   light[n] <= ~ch_phase[n][PWM_W];
          default:      light[n] <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: doc/multi_breathing_light.md
MULTI_BREATHING_LIGHT -- requirements
Module: multi_breathing_light

Interface
REQ-001 The block SHALL have parameter CH, default 4, number of independent LED channels (1..16).
REQ-002 The block SHALL have parameter PWM_W, default 8, PWM counter and brightness width (2..12).
REQ-003 The block SHALL have parameter STEP_DIV, default 78125, clock cycles per brightness step (>=1).
REQ-004 The block SHALL have port clk, input, 1, the single system clock.
REQ-005 The block SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-006 The block SHALL have port hold, input, 1, which freezes the brightness ramp while high.
REQ-007 The block SHALL have port mode, input, 2*CH, the per-channel mode; channel n uses bits [2n+1:2n]: 00 off, 01 on, 10 breathe, 11 blink.
REQ-008 The block SHALL have port light, output, CH, the registered per-channel LED drive.
REQ-009 The block SHALL have port cycle_done, output, 1, a one-cycle pulse at each breathing-period wrap.

Function
REQ-010 The prescaler SHALL count 0..STEP_DIV-1 and assert step for one cycle when at STEP_DIV-1 with hold low, then return to 0.
REQ-011 The phase counter P, PWM_W+1 bits, SHALL increment by 1 on each step and wrap from 2^(PWM_W+1)-1 to 0.
REQ-012 cycle_done SHALL be high exactly in the cycle after P wraps to 0.
REQ-013 Channel n phase SHALL be Pn = (P + n*(2^(PWM_W+1)/CH)) mod 2^(PWM_W+1), using integer division.
REQ-014 Channel n triangle level SHALL be Pn[PWM_W-1:0] when Pn[PWM_W]=0, and the bitwise inverse of Pn[PWM_W-1:0] otherwise.
REQ-015 The PWM counter, PWM_W bits, SHALL free-run 0..2^PWM_W-1 and wrap every clock, independent of hold.
REQ-016 Each channel's active duty and active mode SHALL be sampled only in the cycle the PWM counter equals 2^PWM_W-1, so that each PWM period is glitch-free.
REQ-017 light[n] SHALL be registered and driven as: off gives 0; on gives 1; breathe gives (pwm_cnt < active duty); blink gives NOT Pn[PWM_W].
REQ-018 A mode change SHALL take effect at the first PWM period boundary after it, and no earlier.
REQ-019 While hold is high, the prescaler and P SHALL freeze, cycle_done SHALL stay 0, and PWM output SHALL continue at the frozen duty.
REQ-020 A duty of 0 SHALL give constant 0; the maximum breathe duty 2^PWM_W-1 SHALL give light high for 2^PWM_W-1 of 2^PWM_W cycles.

Reset
REQ-021 While rst is high at a clk edge, the prescaler, P, PWM counter, active duties and active modes SHALL all become 0.
REQ-022 While rst is high at a clk edge, light SHALL become all 0 and cycle_done SHALL become 0.
REQ-023 Reset asserted mid-period SHALL abort the ramp, and counting SHALL restart from 0 on the first edge after rst falls.

Configuration
REQ-024 The macro BREATH_GAMMA_EN SHALL select the duty law for breathe mode.
REQ-025 When BREATH_GAMMA_EN is defined, breathe duty SHALL be (level*level) >> PWM_W, computed at full 2*PWM_W-bit width before the shift.
REQ-026 When BREATH_GAMMA_EN is undefined, breathe duty SHALL equal the linear level, and no multiplier SHALL be instantiated.

Verification
All scenarios use CH=4, PWM_W=4, STEP_DIV=2 unless noted.
REQ-027 Reset check: assert rst for 3 cycles with mode=all 10 -> light=0000 and cycle_done=0 during and 1 cycle after reset; first cycle_done pulse arrives 64 cycles after release.
REQ-028 Phase offsets: breathe on all channels, P=5 -> channel levels 5, 13, 10 and 2 (channel 2 is 21 inverted, channel 3 is 29 inverted).
REQ-029 Duty check, linear build: channel 0 level 5 -> light[0] high for exactly 5 of 16 cycles in the following PWM period.
REQ-030 Duty check, BREATH_GAMMA_EN build: channel 0 level 5 -> duty 1, high 1 of 16; level 15 -> duty 14, high 14 of 16.
REQ-031 Hold: raise hold for 100 cycles -> P constant, no cycle_done, PWM pattern repeats identically every 16 cycles.
REQ-032 Mode switch: change mode[1:0] from 10 to 01 at pwm_cnt=7 -> light[0] follows the old duty until pwm_cnt wraps, then stays at constant 1.
